// File: rtl/wm_pkg.sv
// Shared phase codes, FSM state encoding and the time-counter width for the
// washer-machine phase timer.
package wm_pkg;

  localparam int unsigned TIME_W = 16;

  localparam logic [2:0] PH_NONE  = 3'd0;
  localparam logic [2:0] PH_SOAK  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_RINSE = 3'd3;
  localparam logic [2:0] PH_SPIN  = 3'd4;

  typedef logic [2:0] wm_state_t;

  localparam wm_state_t ST_IDLE  = 3'd0;
  localparam wm_state_t ST_LOAD  = 3'd1;
  localparam wm_state_t ST_RUN   = 3'd2;
  localparam wm_state_t ST_PAUSE = 3'd3;
  localparam wm_state_t ST_DONE  = 3'd4;

  // Operation vector is {spin, rinse, wash, soak}; anything not one-hot maps to none.
  function automatic logic [2:0] op_to_phase(input logic [3:0] op);
    case (op)
      4'b0001: return PH_SOAK;
      4'b0010: return PH_WASH;
      4'b0100: return PH_RINSE;
      4'b1000: return PH_SPIN;
      default: return PH_NONE;
    endcase
  endfunction

  function automatic logic op_multi(input logic [3:0] op);
    return (op & (op - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Tick prescaler: one-cycle tick every DIV enabled cycles; clear restarts the
// period and a low enable freezes the count.
module wm_tick_prescaler #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Washer phase timer: times each controller operation phase and pulses phase_Done.
// Optional lid pause (RUN <-> PAUSE with frozen timing) is built with WM_LID_PAUSE_EN.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned SOAK_TICKS  = 600,
  parameter int unsigned WASH_TICKS  = 900,
  parameter int unsigned RINSE_TICKS = 300,
  parameter int unsigned SPIN_TICKS  = 240
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soak_Operation,
  input  logic              wash_Operation,
  input  logic              rinse_Operation,
  input  logic              spin_Operation,
  input  logic              lid,
  input  logic              cancel,
  output logic              phase_Done,
  output logic [TIME_W-1:0] time_Remaining,
  output logic [2:0]        phase_Code,
  output logic              op_Error
);

  logic [3:0]        op_q;
  wm_state_t         state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q;

  logic [2:0] op_code;
  logic       op_bad;
  logic       run_en;
  logic       presc_clear;
  logic       tick;

  assign op_code = op_to_phase(op_q);
  assign op_bad  = op_multi(op_q);

  function automatic logic [TIME_W-1:0] ticks_for(input logic [2:0] ph);
    case (ph)
      PH_SOAK:  return TIME_W'(SOAK_TICKS);
      PH_WASH:  return TIME_W'(WASH_TICKS);
      PH_RINSE: return TIME_W'(RINSE_TICKS);
      PH_SPIN:  return TIME_W'(SPIN_TICKS);
      default:  return '0;
    endcase
  endfunction

`ifdef WM_LID_PAUSE_EN
  // The prescaler counts in PAUSE as well, so the cycle the lid closes is not lost.
  assign run_en = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !lid;
`else
  assign run_en = (state_q == ST_RUN);
  logic unused_lid;
  assign unused_lid = lid;
`endif

  assign presc_clear = (state_q != ST_RUN) && (state_q != ST_PAUSE);

  wm_tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i   (clock),
    .rst_i   (reset),
    .en_i    (run_en),
    .clear_i (presc_clear),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (cancel) begin
      state_d = ST_IDLE;
      phase_d = PH_NONE;
      cnt_d   = '0;
    end else if (op_bad) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
      phase_d = PH_NONE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!err_q && (op_code != PH_NONE)) begin
            state_d = ST_LOAD;
            phase_d = op_code;
          end
        end
        ST_LOAD: begin
          cnt_d   = ticks_for(phase_q);
          state_d = (cnt_d == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN, ST_PAUSE, ST_DONE: begin
          // A phase change abandons the current phase without a done pulse.
          if (op_code != phase_q) begin
            if (op_code == PH_NONE) begin
              state_d = ST_IDLE;
              phase_d = PH_NONE;
              cnt_d   = '0;
            end else begin
              state_d = ST_LOAD;
              phase_d = op_code;
            end
          end else if (state_q != ST_DONE) begin
`ifdef WM_LID_PAUSE_EN
            state_d = lid ? ST_PAUSE : ST_RUN;
`endif
            if (tick) begin
              if (cnt_q != '0) begin
                cnt_d = cnt_q - TIME_W'(1);
              end
              if (cnt_q <= TIME_W'(1)) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = PH_NONE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q    <= '0;
      state_q <= ST_IDLE;
      phase_q <= PH_NONE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      op_q    <= {spin_Operation, rinse_Operation, wash_Operation, soak_Operation};
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign phase_Done     = done_q;
  assign time_Remaining = cnt_q;
  assign phase_Code     = phase_q;
  assign op_Error       = err_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Randomized scoreboard bench for wm_phase_timer against an elapsed-time
// reference model of the phase timing rules.
module tb_wm_phase_timer;

  localparam int unsigned D       = 4;
  localparam int unsigned T_SOAK  = 0;
  localparam int unsigned T_WASH  = 3;
  localparam int unsigned T_RINSE = 6;
  localparam int unsigned T_SPIN  = 5;

`ifdef WM_LID_PAUSE_EN
  localparam bit LID_EN = 1'b1;
`else
  localparam bit LID_EN = 1'b0;
`endif

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_SOAK  = 4'b0001;
  localparam logic [3:0] OP_WASH  = 4'b0010;
  localparam logic [3:0] OP_RINSE = 4'b0100;
  localparam logic [3:0] OP_SPIN  = 4'b1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        soak_Operation = 1'b0;
  logic        wash_Operation = 1'b0;
  logic        rinse_Operation = 1'b0;
  logic        spin_Operation = 1'b0;
  logic        lid = 1'b0;
  logic        cancel = 1'b0;
  logic        phase_Done;
  logic [15:0] time_Remaining;
  logic [2:0]  phase_Code;
  logic        op_Error;

  wm_phase_timer #(
    .TICK_DIV    (D),
    .SOAK_TICKS  (T_SOAK),
    .WASH_TICKS  (T_WASH),
    .RINSE_TICKS (T_RINSE),
    .SPIN_TICKS  (T_SPIN)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .soak_Operation  (soak_Operation),
    .wash_Operation  (wash_Operation),
    .rinse_Operation (rinse_Operation),
    .spin_Operation  (spin_Operation),
    .lid             (lid),
    .cancel          (cancel),
    .phase_Done      (phase_Done),
    .time_Remaining  (time_Remaining),
    .phase_Code      (phase_Code),
    .op_Error        (op_Error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        done;
    logic [15:0] rem;
    logic [2:0]  code;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc_no   = 0;

  // Reference model: a phase is a budget of T*D counting cycles; time left is
  // T minus whole ticks elapsed, and done fires when the budget is used up.
  typedef enum { M_IDLE, M_LOADING, M_TIMING, M_FINISHED } mstage_t;
  mstage_t     m_stage   = M_IDLE;
  logic [3:0]  m_op      = '0;
  bit          m_err     = 1'b0;
  int unsigned m_ph      = 0;
  int unsigned m_rem     = 0;
  int unsigned m_elapsed = 0;
  int unsigned m_total   = 0;

  function automatic int unsigned ticks_of(input int unsigned ph);
    case (ph)
      1: return T_SOAK;
      2: return T_WASH;
      3: return T_RINSE;
      4: return T_SPIN;
      default: return 0;
    endcase
  endfunction

  task automatic model_idle();
    m_stage = M_IDLE;
    m_ph    = 0;
    m_rem   = 0;
  endtask

  task automatic model_step(input logic [3:0] op, input logic l, input logic c, input logic r);
    exp_t        e;
    int unsigned ones;
    int unsigned code;
    bit          pulse;
    pulse = 1'b0;
    ones  = $countones(m_op);
    code  = 0;
    if (ones == 1) code = m_op[0] ? 1 : m_op[1] ? 2 : m_op[2] ? 3 : 4;
    if (r) begin
      model_idle();
      m_err = 1'b0;
      m_op  = '0;
    end else begin
      if (c) begin
        model_idle();
      end else if (ones > 1) begin
        m_err = 1'b1;
        model_idle();
      end else begin
        case (m_stage)
          M_IDLE: if (!m_err && code != 0) begin
            m_stage = M_LOADING;
            m_ph    = code;
          end
          M_LOADING: begin
            m_total   = ticks_of(m_ph) * D;
            m_elapsed = 0;
            m_rem     = ticks_of(m_ph);
            if (m_total == 0) begin
              m_stage = M_FINISHED;
              pulse   = 1'b1;
            end else begin
              m_stage = M_TIMING;
            end
          end
          default: begin
            if (code != m_ph) begin
              if (code == 0) model_idle();
              else begin
                m_stage = M_LOADING;
                m_ph    = code;
              end
            end else if (m_stage == M_TIMING && !(LID_EN && l)) begin
              m_elapsed++;
              m_rem = ticks_of(m_ph) - m_elapsed / D;
              if (m_elapsed == m_total) begin
                m_stage = M_FINISHED;
                pulse   = 1'b1;
              end
            end
          end
        endcase
      end
      m_op = op;
    end
    e.done = pulse;
    e.rem  = 16'(m_rem);
    e.code = 3'(m_ph);
    e.err  = m_err;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] op, input logic l, input logic c, input logic r);
    @(negedge clock);
    {spin_Operation, rinse_Operation, wash_Operation, soak_Operation} = op;
    lid    = l;
    cancel = c;
    reset  = r;
    model_step(op, l, c, r);
  endtask

  task automatic hold(input logic [3:0] op, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(op, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expected output record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (phase_Done === e.done && time_Remaining === e.rem &&
            phase_Code === e.code && op_Error === e.err) begin
          n_pass++;
        end else begin
          $display("FAIL outputs cycle %0d: got done=%0b rem=%0d code=%0d err=%0b, want done=%0b rem=%0d code=%0d err=%0b",
                   cyc_no, phase_Done, time_Remaining, phase_Code, op_Error,
                   e.done, e.rem, e.code, e.err);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    int unsigned pick, len, a, b;
    logic        l, c, r;

    // Reset state.
    cyc(OP_NONE, 1'b0, 1'b0, 1'b1);
    cyc(OP_NONE, 1'b0, 1'b0, 1'b1);
    hold(OP_NONE, 2);

    // Wash held: one load, one pulse, countdown 3..0.
    hold(OP_WASH, 24);
    hold(OP_NONE, 3);

    // Zero-tick soak: immediate pulse, no repeat while held.
    hold(OP_SOAK, 10);
    hold(OP_NONE, 2);

    // Phase switch mid-run: no pulse for the abandoned phase.
    hold(OP_RINSE, 12);
    hold(OP_SPIN, 30);
    hold(OP_NONE, 2);

    // Lid open for 10 cycles after the second tick.
    hold(OP_SPIN, 11);
    for (int unsigned i = 0; i < 10; i++) cyc(OP_SPIN, 1'b1, 1'b0, 1'b0);
    hold(OP_SPIN, 16);
    hold(OP_NONE, 2);

    // Cancel mid-run, reset mid-run, then both together.
    hold(OP_RINSE, 9);
    cyc(OP_RINSE, 1'b0, 1'b1, 1'b0);
    hold(OP_NONE, 2);
    hold(OP_WASH, 8);
    cyc(OP_WASH, 1'b0, 1'b0, 1'b1);
    hold(OP_NONE, 2);
    hold(OP_RINSE, 9);
    cyc(OP_RINSE, 1'b0, 1'b1, 1'b1);
    hold(OP_NONE, 2);

    // Two operation bits together: sticky error, later phases blocked.
    hold(OP_SOAK | OP_SPIN, 2);
    hold(OP_WASH, 20);
    cyc(OP_NONE, 1'b0, 1'b0, 1'b1);
    hold(OP_WASH, 20);
    hold(OP_NONE, 2);

    // Randomized segments.
    for (int unsigned s = 0; s < 250; s++) begin
      pick = $urandom_range(0, 99);
      len  = $urandom_range(1, 30);
      if (pick < 10) begin
        op = OP_NONE;
      end else if (pick < 14) begin
        a  = $urandom_range(0, 3);
        b  = (a + 1 + $urandom_range(0, 2)) % 4;
        op = 4'(1 << a) | 4'(1 << b);
      end else begin
        op = 4'(1 << $urandom_range(0, 3));
      end
      for (int unsigned i = 0; i < len; i++) begin
        l = ($urandom_range(0, 4) == 0);
        c = ($urandom_range(0, 79) == 0);
        r = (m_err && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
        cyc(op, l, c, r);
      end
    end

    hold(OP_NONE, 2);
    repeat (3) @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d records left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
